// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the filter frame sequencer.
package filter_seq_pkg;

    localparam int DEF_H_PIX = 640;
    localparam int DEF_V_PIX = 480;
    localparam int TOTAL_PIX = DEF_H_PIX * DEF_V_PIX;

    // Filter codes understood by the colour-filter core
    typedef enum logic [3:0] {
        MODE_PASS      = 4'b0001,
        MODE_GRAY      = 4'b0010,
        MODE_MELT      = 4'b0011,
        MODE_FREEZE    = 4'b0100,
        MODE_NOSTALGIC = 4'b0101,
        MODE_REVERSE   = 4'b0110
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // True when the code names a filter the core implements
    function automatic logic mode_legal(input logic [3:0] m);
        return (m >= MODE_PASS) && (m <= MODE_REVERSE);
    endfunction

endpackage

// File: rtl/pixel_pipe_delay.sv
// Valid + address delay line with a common stall enable.
// vld_o exposes every stage so the owner can tell when the line is empty.
module pixel_pipe_delay #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DEPTH-1:0]  vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

    // Shift one stage per enabled cycle; everything holds when en_i is low
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else if (en_i) begin
            vld_q[0]  <= vld_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/filter_frame_sequencer.sv
// Walks one frame of source pixels through the colour-filter core and
// produces the aligned destination write strobe/address.
// FILTER_SEQ_CONTINUOUS_EN: when defined, frames loop back-to-back after the
// first start instead of returning to IDLE.
module filter_frame_sequencer
    import filter_seq_pkg::*;
#(
    parameter int H_PIX    = DEF_H_PIX,
    parameter int V_PIX    = DEF_V_PIX,
    parameter int ADDR_W   = 19,
    parameter int MEM_LAT  = 1,
    parameter int CORE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode_req,
    input  logic              mode_req_valid,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] src_addr,
    output logic [3:0]        core_mode,
    output logic [ADDR_W-1:0] core_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              dst_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_count
);

    localparam int                TOTAL     = H_PIX * V_PIX;
    localparam int                DEPTH     = MEM_LAT + CORE_LAT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [3:0]        pending_q, pending_d;
    logic [3:0]        active_q, active_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic [3:0]        req_mode;
    logic              issue;
    logic              pipe_idle;
    logic [MEM_LAT-1:0] core_vld;
    logic [DEPTH-1:0]   dst_vld;

    // Unknown codes fall back to pass-through so the core never sees junk
    assign req_mode = mode_legal(mode_req) ? mode_req : MODE_PASS;

    // Frame FSM, address walker and mode latch. Mode requests are captured even
    // while stalled so a one-cycle strobe is never lost; everything else holds.
    // The newest request wins when it coincides with the frame start, hence
    // active takes pending_d rather than pending_q.
    always_comb begin
        state_d       = state_q;
        src_addr_d    = src_addr_q;
        active_d      = active_q;
        frame_count_d = frame_count_q;
        pending_d     = mode_req_valid ? req_mode : pending_q;
        issue         = 1'b0;
        done          = 1'b0;
        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_RUN;
                        src_addr_d = '0;
                        active_d   = pending_d;
                    end
                end
                ST_RUN: begin
                    issue = 1'b1;
                    if (src_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        src_addr_d = src_addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (pipe_idle) state_d = ST_DONE;
                end
                ST_DONE: begin
                    done          = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
`ifdef FILTER_SEQ_CONTINUOUS_EN
                    state_d    = ST_RUN;
                    src_addr_d = '0;
                    active_d   = pending_d;
`else
                    state_d    = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            src_addr_q    <= '0;
            pending_q     <= MODE_PASS;
            active_q      <= MODE_PASS;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            src_addr_q    <= src_addr_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Address as seen by the core, one memory latency after issue
    pixel_pipe_delay #(.DEPTH(MEM_LAT), .ADDR_W(ADDR_W)) u_core_dly (
        .clk    (clk),
        .rst    (rst),
        .en_i   (!stall),
        .vld_i  (issue),
        .addr_i (src_addr_q),
        .vld_o  (core_vld),
        .addr_o (core_addr)
    );

    // Address/valid aligned with the core's filtered output
    pixel_pipe_delay #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dst_dly (
        .clk    (clk),
        .rst    (rst),
        .en_i   (!stall),
        .vld_i  (issue),
        .addr_i (src_addr_q),
        .vld_o  (dst_vld),
        .addr_o (dst_addr)
    );

    assign pipe_idle   = ~|core_vld && ~|dst_vld;
    assign dst_we      = dst_vld[DEPTH-1] && !stall;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign src_addr    = src_addr_q;
    assign core_mode   = active_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer on a reduced 8x4 frame.
module tb_filter_frame_sequencer;

    localparam int H = 8;
    localparam int V = 4;
    localparam int TOT = H * V;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst, start, stall, mode_req_valid;
    logic [3:0]    mode_req;
    logic [AW-1:0] src_addr, core_addr, dst_addr;
    logic [3:0]    core_mode;
    logic          dst_we, busy, done;
    logic [7:0]    frame_count;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int exp_addr = 0;
    logic [3:0] exp_mode = 4'd1;
    logic got;

    filter_frame_sequencer #(
        .H_PIX(H), .V_PIX(V), .ADDR_W(AW), .MEM_LAT(1), .CORE_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .start(start), .stall(stall), .src_addr(src_addr), .core_mode(core_mode),
        .core_addr(core_addr), .dst_addr(dst_addr), .dst_we(dst_we), .busy(busy),
        .done(done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    // Write scoreboard: every write is the next address in order, with the frame's mode
    always @(negedge clk) begin
        if (rst) begin
            exp_addr = 0;
        end else if (dst_we) begin
            chk("wr_addr", 32'(dst_addr), 32'(exp_addr));
            chk("wr_mode", 32'(core_mode), 32'(exp_mode));
            exp_addr = (exp_addr == TOT - 1) ? 0 : exp_addr + 1;
            wr_cnt++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; mode_req = 4'd0; mode_req_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_src", 32'(src_addr), 32'd0);
        chk("rst_core_addr", 32'(core_addr), 32'd0);
        chk("rst_dst", 32'(dst_addr), 32'd0);
        chk("rst_we", 32'(dst_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_mode", 32'(core_mode), 32'd1);

`ifdef FILTER_SEQ_CONTINUOUS_EN
        begin
            int nd;
            int last_done;
            int cyc;
            nd = 0; last_done = 0; cyc = 0;
            tick(); mode_req = 4'd3; mode_req_valid = 1'b1; start = 1'b1; exp_mode = 4'd3;
            tick(); mode_req_valid = 1'b0; start = 1'b0;
            @(negedge clk);
            chk("cont_mode", 32'(core_mode), 32'd3);
            while (nd < 3 && cyc < 400) begin
                tick(); cyc++;
                @(negedge clk);
                if (done) begin
                    if (nd > 0) chk("cont_period", 32'(cyc - last_done), 32'(TOT + 4));
                    last_done = cyc;
                    nd++;
                end
            end
            chk("cont_3_dones", 32'(nd), 32'd3);
            tick();
            @(negedge clk);
            chk("cont_fc", 32'(frame_count), 32'd3);
            chk("cont_busy", 32'(busy), 32'd1);
            chk("cont_writes", 32'(wr_cnt), 32'(3 * TOT));
            tick(); rst = 1'b1;
            tick(); rst = 1'b0;
        end
`else
        // Frame 1: gray, with a mid-frame mode request and a 5-cycle stall
        tick(); mode_req = 4'd2; mode_req_valid = 1'b1;
        tick(); mode_req_valid = 1'b0; start = 1'b1; exp_mode = 4'd2;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        tick(); start = 1'b0;
        @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_src0", 32'(src_addr), 32'd0);
        chk("run_mode", 32'(core_mode), 32'd2);
        chk("run_we0", 32'(dst_we), 32'd0);
        tick();
        @(negedge clk);
        chk("c2_core_addr", 32'(core_addr), 32'd0);
        chk("c2_we", 32'(dst_we), 32'd0);
        tick();
        @(negedge clk);
        chk("c3_we", 32'(dst_we), 32'd1);
        chk("c3_dst", 32'(dst_addr), 32'd0);
        tick(); mode_req = 4'd5; mode_req_valid = 1'b1;
        @(negedge clk);
        chk("mid_mode_hold", 32'(core_mode), 32'd2);
        tick(); mode_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); stall = 1'b1;
            @(negedge clk);
            chk("stall_src", 32'(src_addr), 32'd5);
            chk("stall_core", 32'(core_addr), 32'd4);
            chk("stall_dst", 32'(dst_addr), 32'd3);
            chk("stall_we", 32'(dst_we), 32'd0);
        end
        tick(); stall = 1'b0;
        @(negedge clk);
        chk("unstall_we", 32'(dst_we), 32'd1);
        chk("unstall_dst", 32'(dst_addr), 32'd3);
        wait_done(200);
        chk("f1_src_last", 32'(src_addr), 32'(TOT - 1));
        chk("f1_writes", 32'(wr_cnt), 32'(TOT));
        chk("f1_mode", 32'(core_mode), 32'd2);
        tick();
        @(negedge clk);
        chk("f1_fc", 32'(frame_count), 32'd1);
        chk("f1_done_pulse", 32'(done), 32'd0);
        chk("f1_busy", 32'(busy), 32'd0);

        // Frame 2: pending nostalgic request is applied at this start
        wr_cnt = 0;
        tick(); start = 1'b1; exp_mode = 4'd5;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("f2_mode", 32'(core_mode), 32'd5);
        chk("f2_src0", 32'(src_addr), 32'd0);
        wait_done(200);
        chk("f2_writes", 32'(wr_cnt), 32'(TOT));
        tick();
        @(negedge clk);
        chk("f2_fc", 32'(frame_count), 32'd2);

        // Frame 3: illegal code coincident with start, then start while running
        wr_cnt = 0;
        tick(); mode_req = 4'b1001; mode_req_valid = 1'b1; start = 1'b1; exp_mode = 4'd1;
        tick(); mode_req_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("f3_illegal_mode", 32'(core_mode), 32'd1);
        chk("f3_src0", 32'(src_addr), 32'd0);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("f3_start_ignored", 32'(src_addr), 32'd2);
        chk("f3_busy", 32'(busy), 32'd1);
        wait_done(200);
        chk("f3_writes", 32'(wr_cnt), 32'(TOT));
        tick();
        @(negedge clk);
        chk("f3_fc", 32'(frame_count), 32'd3);

        // Reset mid-frame, then a fresh frame from address 0
        wr_cnt = 0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("mrst_src", 32'(src_addr), 32'd0);
        chk("mrst_core", 32'(core_addr), 32'd0);
        chk("mrst_dst", 32'(dst_addr), 32'd0);
        chk("mrst_we", 32'(dst_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_fc", 32'(frame_count), 32'd0);
        chk("mrst_mode", 32'(core_mode), 32'd1);
        wr_cnt = 0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("f4_src0", 32'(src_addr), 32'd0);
        wait_done(200);
        chk("f4_writes", 32'(wr_cnt), 32'(TOT));
        tick();
        @(negedge clk);
        chk("f4_fc", 32'(frame_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
